stream_accumulator: RTL

- Sequential front-end for the team's 5-bit ripple adder: accepts a stream of unsigned operands over a valid/ready handshake and accumulates them packet by packet.
- Each accepted beat feeds the adder with the running sum plus the new operand. The adder's sum and carry-out are registered back into the accumulator.
- At end of packet it presents the wrapped sum, a sticky overflow flag and the beat count to a downstream consumer.

---
 rtl/stream_acc_pkg.sv | 17 +
 rtl/acc_adder.sv | 24 ++
 rtl/stream_accumulator.sv | 117 +++++++++++
 3 files changed

// File: rtl/stream_acc_pkg.sv
// Shared types and defaults for the stream accumulator and its adder.
package stream_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    localparam int DEFAULT_WIDTH   = 5;
    localparam int DEFAULT_MAX_LEN = 8;

    // Bits needed to hold a beat count of 0..max_len inclusive.
    function automatic int count_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/acc_adder.sv
// Combinational ripple-carry adder; drop-in equivalent of the 5-bit team adder at WIDTH=5.
module acc_adder #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign carry_out = carry[WIDTH];

endmodule

// File: rtl/stream_accumulator.sv
// Packet accumulator: sums a valid/ready operand stream per packet and presents
// sum, sticky overflow and beat count until the consumer takes the result.
module stream_accumulator
    import stream_acc_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    localparam int CW     = count_width(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_overflow,
    output logic [CW-1:0]    out_count,
    output logic             out_forced
);

    localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_LEN);

    acc_state_e       state_reg,    state_next;
    logic [WIDTH-1:0] acc_reg,      acc_next;
    logic             sticky_reg,   sticky_next;
    logic [CW-1:0]    count_reg,    count_next;
    logic [WIDTH-1:0] sum_reg,      sum_next;
    logic             overflow_reg, overflow_next;
    logic [CW-1:0]    out_count_reg, out_count_next;
    logic             forced_reg,   forced_next;

    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic [CW-1:0]    count_inc;
    logic             accept;

    acc_adder #(.WIDTH(WIDTH)) u_adder (
        .a         (acc_reg),
        .b         (in_data),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    // Gating with rst_n keeps in_ready low while reset is held.
    assign in_ready  = rst_n && (state_reg == ACCUM);
    assign out_valid = (state_reg == HOLD);
    assign accept    = in_valid && in_ready;
    assign count_inc = count_reg + CW'(1);

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        sticky_next    = sticky_reg;
        count_next     = count_reg;
        sum_next       = sum_reg;
        overflow_next  = overflow_reg;
        out_count_next = out_count_reg;
        forced_next    = forced_reg;

        case (state_reg)
            ACCUM: begin
                if (accept) begin
                    acc_next    = add_sum;
                    sticky_next = sticky_reg | add_carry;
                    count_next  = count_inc;
                    if (in_last || (count_inc == MAX_COUNT)) begin
                        state_next     = HOLD;
                        sum_next       = add_sum;
                        overflow_next  = sticky_reg | add_carry;
                        out_count_next = count_inc;
                        forced_next    = !in_last;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next  = ACCUM;
                    acc_next    = '0;
                    sticky_next = 1'b0;
                    count_next  = '0;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            sticky_reg    <= 1'b0;
            count_reg     <= '0;
            sum_reg       <= '0;
            overflow_reg  <= 1'b0;
            out_count_reg <= '0;
            forced_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            sticky_reg    <= sticky_next;
            count_reg     <= count_next;
            sum_reg       <= sum_next;
            overflow_reg  <= overflow_next;
            out_count_reg <= out_count_next;
            forced_reg    <= forced_next;
        end
    end

    assign out_sum      = sum_reg;
    assign out_overflow = overflow_reg;
    assign out_count    = out_count_reg;
    assign out_forced   = forced_reg;

endmodule
